// File: rtl/song_seq_pkg.sv
// Shared constants and helpers for the song sequencer: position width, drum decay maxima,
// default tempo/pattern values and divider width sizing.
package song_seq_pkg;

  localparam int              SONGPOS_W          = 8;
  localparam logic [2:0]      KICK_MAX           = 3'd7;
  localparam logic [3:0]      SNARE_MAX          = 4'd15;

  localparam int              DEF_ROW_CYCLES     = 5229082;
  localparam int              DEF_FRAME_CYCLES   = 800625;
  localparam logic [15:0]     DEF_KICK_PATTERN   = 16'h1111;
  localparam logic [15:0]     DEF_SNARE_PATTERN  = 16'h1010;
  localparam int              DEF_KICK_START     = 32;
  localparam int              DEF_SWING_CYCLES   = 200000;

  // A divider counts period-1 down to 0, so ceil(log2(period)) bits suffice; never fewer than 1.
  function automatic int div_width(input int max_period);
    return (max_period > 1) ? $clog2(max_period) : 1;
  endfunction

endpackage

// File: rtl/song_sequencer_tick_divider.sv
// Reloadable down-counter: emits a one-cycle combinational tick when it expires while enabled.
module tick_divider #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk48,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] reload_val,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && !clear && (cnt_q == '0);
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = reload_val;
    end else if (en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Music-timing sequencer: row/frame dividers advance the song position and drive kick/snare decay
// counters. Optional swing timing is enabled by defining SONG_SEQ_SWING_EN.
module song_sequencer
  import song_seq_pkg::*;
#(
  parameter int          ROW_CYCLES    = DEF_ROW_CYCLES,
  parameter int          FRAME_CYCLES  = DEF_FRAME_CYCLES,
  parameter logic [15:0] KICK_PATTERN  = DEF_KICK_PATTERN,
  parameter logic [15:0] SNARE_PATTERN = DEF_SNARE_PATTERN,
  parameter int          KICK_START    = DEF_KICK_START,
  parameter int          SWING_CYCLES  = DEF_SWING_CYCLES
) (
  input  logic                 clk48,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 restart,
  output logic [SONGPOS_W-1:0] songpos_out,
  output logic [2:0]           kick_frames_out,
  output logic [3:0]           snare_frames_out,
  output logic                 row_strobe,
  output logic                 frame_strobe
);

  localparam int               ROW_W        = div_width(ROW_CYCLES + SWING_CYCLES);
  localparam int               FRAME_W      = div_width(FRAME_CYCLES);
  localparam logic [FRAME_W-1:0] FRAME_RELOAD = FRAME_W'(FRAME_CYCLES - 1);
`ifdef SONG_SEQ_SWING_EN
  localparam logic [ROW_W-1:0] ROW_LONG     = ROW_W'(ROW_CYCLES + SWING_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_SHORT    = ROW_W'(ROW_CYCLES - SWING_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_RESET    = ROW_LONG;
`else
  localparam logic [ROW_W-1:0] ROW_RESET    = ROW_W'(ROW_CYCLES - 1);
`endif

  logic [SONGPOS_W-1:0] songpos_q, songpos_d, songpos_inc;
  logic [2:0]           kick_q, kick_d;
  logic [3:0]           snare_q, snare_d;
  logic                 row_strobe_q, row_strobe_d;
  logic                 frame_strobe_q, frame_strobe_d;
  logic [ROW_W-1:0]     row_reload;
  logic                 row_tick, frame_tick;
  logic                 kick_hit, snare_hit;

  assign songpos_inc = songpos_q + 1'b1;

`ifdef SONG_SEQ_SWING_EN
  // Even-numbered new rows get the long interval, odd ones the short; restart always starts long.
  assign row_reload = (restart || !songpos_inc[0]) ? ROW_LONG : ROW_SHORT;
`else
  assign row_reload = ROW_RESET;
`endif

  tick_divider #(.WIDTH(ROW_W), .RESET_VAL(ROW_RESET)) u_row_div (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .en         (run),
    .clear      (restart),
    .reload_val (row_reload),
    .tick       (row_tick)
  );

  tick_divider #(.WIDTH(FRAME_W), .RESET_VAL(FRAME_RELOAD)) u_frame_div (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .en         (run),
    .clear      (restart),
    .reload_val (FRAME_RELOAD),
    .tick       (frame_tick)
  );

  assign kick_hit  = KICK_PATTERN[songpos_inc[3:0]] && (int'(songpos_inc) >= KICK_START);
  assign snare_hit = SNARE_PATTERN[songpos_inc[3:0]];

  always_comb begin
    songpos_d      = songpos_q;
    kick_d         = kick_q;
    snare_d        = snare_q;
    row_strobe_d   = 1'b0;
    frame_strobe_d = 1'b0;
    if (restart) begin
      songpos_d = '0;
      kick_d    = '0;
      snare_d   = '0;
    end else begin
      if (frame_tick) begin
        frame_strobe_d = 1'b1;
        if (kick_q != '0)  kick_d  = kick_q - 1'b1;
        if (snare_q != '0) snare_d = snare_q - 1'b1;
      end
      // A fresh hit overrides the same-cycle decay of that counter only.
      if (row_tick) begin
        row_strobe_d = 1'b1;
        songpos_d    = songpos_inc;
        if (kick_hit)  kick_d  = KICK_MAX;
        if (snare_hit) snare_d = SNARE_MAX;
      end
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      songpos_q      <= '0;
      kick_q         <= '0;
      snare_q        <= '0;
      row_strobe_q   <= 1'b0;
      frame_strobe_q <= 1'b0;
    end else begin
      songpos_q      <= songpos_d;
      kick_q         <= kick_d;
      snare_q        <= snare_d;
      row_strobe_q   <= row_strobe_d;
      frame_strobe_q <= frame_strobe_d;
    end
  end

  assign songpos_out      = songpos_q;
  assign kick_frames_out  = kick_q;
  assign snare_frames_out = snare_q;
  assign row_strobe       = row_strobe_q;
  assign frame_strobe     = frame_strobe_q;

endmodule
